if_fetch_stage: RTL

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode (ID) stage. It owns the program counter and drives the instruction-memory address. It latches the returned instruction into the IF/ID pipeline register, producing `inst_ID`, `PC_ID` and `PCadd4_ID` for decode. It honours stall and flush requests from hazard logic, takes branch/jump redirects from EX, and freezes fetch on `ebreak`.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_id_reg.sv | 35 +++
 rtl/if_fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types used by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or bubble, with NOP/zero reset values.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcadd4_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcadd4_o,
  output logic            valid_o
);

  // A bubble is the same image as reset: NOP with zeroed PCs, not valid.
  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      inst_o   <= NOP_INST;
      pc_o     <= '0;
      pcadd4_o <= '0;
      valid_o  <= 1'b0;
    end else if (load_i) begin
      inst_o   <= inst_i;
      pc_o     <= pc_i;
      pcadd4_o <= pcadd4_i;
      valid_o  <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/HALT control
// and the IF/ID register feeding decode.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [31:0]     inst_ID,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] PCadd4_ID,
  output logic            valid_ID,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4, redir_tgt;
  logic            halted_q, halted_d;
  logic            ld, bubble, normal_ld;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign redir_tgt = redirect_pc_i & ~XLEN'(3);
  assign normal_ld = !redirect_i && !stall_i && !flush_i;
  assign imem_addr = pc_q;
  assign halted    = halted_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Entering HALT freezes the PC right away; the visible flag follows one
  // edge later, once the ebreak itself has been handed to decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (normal_ld && imem_rdata == EBREAK_INST) state_d = HALT;
      HALT:    if (redirect_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ld       = 1'b0;
    bubble   = 1'b0;
    halted_d = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_i) begin
          pc_d   = redir_tgt;
          bubble = 1'b1;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (flush_i) begin
          pc_d   = pc_plus4;
          bubble = 1'b1;
        end else begin
          pc_d = pc_plus4;
          ld   = 1'b1;
        end
      end
      HALT: begin
        bubble = 1'b1;
        if (redirect_i) pc_d = redir_tgt;
        else            halted_d = 1'b1;
      end
      default: bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ld),
    .bubble_i (bubble),
    .inst_i   (imem_rdata),
    .pc_i     (pc_q),
    .pcadd4_i (pc_plus4),
    .inst_o   (inst_ID),
    .pc_o     (PC_ID),
    .pcadd4_o (PCadd4_ID),
    .valid_o  (valid_ID)
  );

endmodule
